// File: rtl/hamming_fitness_evaluator_pkg.sv
// rtl/hamming_fitness_evaluator_pkg.sv - shared state encoding and sizing helpers for the fitness evaluator
package hamming_fitness_evaluator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   function automatic int num_chunks(input int total_width, input int chunk_width);
      return (total_width + chunk_width - 1) / chunk_width;
   endfunction

endpackage

// File: rtl/hamming_fitness_evaluator_if.sv
// rtl/hamming_fitness_evaluator_if.sv - individual/fitness handshake bundle; FITNESS_MASK_EN adds the mask word
interface hamming_fitness_evaluator_if #(
   parameter int IndividualWidth = 32,
   parameter int FitnessWidth    = 16
);
   logic                       test_individual;
   logic [IndividualWidth-1:0] individual;
   logic [IndividualWidth-1:0] target;
`ifdef FITNESS_MASK_EN
   logic [IndividualWidth-1:0] mask;
`endif
   logic                       fitness_end;
   logic [FitnessWidth-1:0]    fitness;

`ifdef FITNESS_MASK_EN
   modport master (output test_individual, individual, target, mask, input fitness_end, fitness);
   modport slave  (input test_individual, individual, target, mask, output fitness_end, fitness);
`else
   modport master (output test_individual, individual, target, input fitness_end, fitness);
   modport slave  (input test_individual, individual, target, output fitness_end, fitness);
`endif

endinterface

// File: rtl/hamming_fitness_evaluator_popcount.sv
// rtl/hamming_fitness_evaluator_popcount.sv - combinational count of ones over a Width-bit vector
import hamming_fitness_evaluator_pkg::*;

module hamming_fitness_evaluator_popcount #(
   parameter int Width = 4
) (
   input  logic [Width-1:0]           in_bits,
   output logic [clog2(Width+1)-1:0]  count
);
   localparam int CountW = clog2(Width + 1);

   always_comb begin
      count = '0;
      for (int i = 0; i < Width; i++) begin
         count = count + CountW'(in_bits[i]);
      end
   end

endmodule

// File: rtl/hamming_fitness_evaluator.sv
// rtl/hamming_fitness_evaluator.sv - chunked Hamming-match fitness responder for the compact GA
// Optional FITNESS_MASK_EN restricts scoring to bits with mask=1.
import hamming_fitness_evaluator_pkg::*;

module hamming_fitness_evaluator #(
   parameter int IndividualWidth = 32,
   parameter int FitnessWidth    = 16,
   parameter int ChunkWidth      = 4
) (
   input  logic clk,
   input  logic rst,
   hamming_fitness_evaluator_if.slave bus
);
   localparam int NumChunks = num_chunks(IndividualWidth, ChunkWidth);
   localparam int PadW      = NumChunks * ChunkWidth;
   localparam int AccW      = clog2(IndividualWidth + 1);
   localparam int PcW       = clog2(ChunkWidth + 1);
   localparam int CntW      = clog2(NumChunks + 1);

   state_t                  state_q, state_d;
   logic                    prev_q;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [AccW-1:0]         acc_q, acc_d;
   logic [PcW-1:0]          pc_q, pc_d;
   logic [PadW-1:0]         ind_q, ind_d;
   logic [PadW-1:0]         tgt_q, tgt_d;
   logic [PadW-1:0]         vld_q, vld_d;
   logic [FitnessWidth-1:0] fitness_q, fitness_d;
   logic                    end_q, end_d;

   logic                    start;
   logic [ChunkWidth-1:0]   chunk_match;
   logic [PcW-1:0]          chunk_cnt;
   logic [AccW-1:0]         sum;
   logic [FitnessWidth-1:0] sum_sat;
   logic [PadW-1:0]         latch_vld;

   assign start = bus.test_individual & ~prev_q;

   // Pad bits carry a zero valid flag so they never score as matches.
`ifdef FITNESS_MASK_EN
   assign latch_vld = PadW'(bus.mask);
`else
   assign latch_vld = PadW'({IndividualWidth{1'b1}});
`endif

   assign chunk_match = ~(ind_q[ChunkWidth-1:0] ^ tgt_q[ChunkWidth-1:0]) & vld_q[ChunkWidth-1:0];

   hamming_fitness_evaluator_popcount #(
      .Width(ChunkWidth)
   ) u_popcount (
      .in_bits (chunk_match),
      .count   (chunk_cnt)
   );

   // The chunk count is registered before accumulation, so the sum always lags one chunk.
   assign sum = acc_q + AccW'(pc_q);

   if (AccW > FitnessWidth) begin : g_sat
      assign sum_sat = (|sum[AccW-1:FitnessWidth]) ? {FitnessWidth{1'b1}} : sum[FitnessWidth-1:0];
   end else begin : g_nosat
      assign sum_sat = FitnessWidth'(sum);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      pc_d      = pc_q;
      ind_d     = ind_q;
      tgt_d     = tgt_q;
      vld_d     = vld_q;
      fitness_d = fitness_q;
      end_d     = end_q;
      case (state_q)
         ST_EVAL: begin
            if (cnt_q == CntW'(NumChunks)) begin
               fitness_d = sum_sat;
               end_d     = 1'b1;
               state_d   = ST_DONE;
            end else begin
               acc_d = sum;
               pc_d  = chunk_cnt;
               ind_d = ind_q >> ChunkWidth;
               tgt_d = tgt_q >> ChunkWidth;
               vld_d = vld_q >> ChunkWidth;
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (start) begin
               ind_d   = PadW'(bus.individual);
               tgt_d   = PadW'(bus.target);
               vld_d   = latch_vld;
               acc_d   = '0;
               pc_d    = '0;
               cnt_d   = '0;
               end_d   = 1'b0;
               state_d = ST_EVAL;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         prev_q    <= 1'b0;
         cnt_q     <= '0;
         acc_q     <= '0;
         pc_q      <= '0;
         ind_q     <= '0;
         tgt_q     <= '0;
         vld_q     <= '0;
         fitness_q <= '0;
         end_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= bus.test_individual;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         pc_q      <= pc_d;
         ind_q     <= ind_d;
         tgt_q     <= tgt_d;
         vld_q     <= vld_d;
         fitness_q <= fitness_d;
         end_q     <= end_d;
      end
   end

   assign bus.fitness     = fitness_q;
   assign bus.fitness_end = end_q;

endmodule

// File: tb/tb_hamming_fitness_evaluator.sv
// tb/tb_hamming_fitness_evaluator.sv - self-checking bench: default, saturating and padded evaluator instances
module tb_hamming_fitness_evaluator;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   hamming_fitness_evaluator_if #(.IndividualWidth(32), .FitnessWidth(16)) bus0 ();
   hamming_fitness_evaluator_if #(.IndividualWidth(32), .FitnessWidth(4))  bus1 ();
   hamming_fitness_evaluator_if #(.IndividualWidth(30), .FitnessWidth(16)) bus2 ();

   hamming_fitness_evaluator #(.IndividualWidth(32), .FitnessWidth(16), .ChunkWidth(4)) dut0 (
      .clk (clk), .rst (rst), .bus (bus0.slave));
   hamming_fitness_evaluator #(.IndividualWidth(32), .FitnessWidth(4), .ChunkWidth(4)) dut1 (
      .clk (clk), .rst (rst), .bus (bus1.slave));
   hamming_fitness_evaluator #(.IndividualWidth(30), .FitnessWidth(16), .ChunkWidth(4)) dut2 (
      .clk (clk), .rst (rst), .bus (bus2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Score = number of scored positions where individual equals target, clipped to the fitness range.
   function automatic int ref_fit(input bit [31:0] ind, input bit [31:0] tgt, input bit [31:0] msk,
                                  input int iw, input int fw);
      bit [31:0] keep;
      int        n;
      int        mx;
      keep = (iw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << iw) - 32'h1);
`ifndef FITNESS_MASK_EN
      msk = 32'hFFFF_FFFF;
`endif
      n  = $countones(~(ind ^ tgt) & msk & keep);
      mx = (1 << fw) - 1;
      return (n > mx) ? mx : n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit [31:0] ind, input bit [31:0] tgt, input bit [31:0] msk, input bit ti);
      bus0.individual = ind;        bus0.target = tgt;
      bus1.individual = ind;        bus1.target = tgt;
      bus2.individual = ind[29:0];  bus2.target = tgt[29:0];
`ifdef FITNESS_MASK_EN
      bus0.mask = msk; bus1.mask = msk; bus2.mask = msk[29:0];
`else
      if (msk == 32'h0) ; // mask input has no port in this build
`endif
      bus0.test_individual = ti;
      bus1.test_individual = ti;
      bus2.test_individual = ti;
   endtask

   task automatic set_ti(input bit ti);
      bus0.test_individual = ti;
      bus1.test_individual = ti;
      bus2.test_individual = ti;
   endtask

   // mode 0: single pulse; mode 1: strobe held high; mode 2: second edge three cycles into EVAL
   task automatic run_eval(input string tag, input bit [31:0] ind, input bit [31:0] tgt,
                           input bit [31:0] msk, input int mode);
      int e0, e1, e2;
      e0 = ref_fit(ind, tgt, msk, 32, 16);
      e1 = ref_fit(ind, tgt, msk, 32, 4);
      e2 = ref_fit(ind, tgt, msk, 30, 16);
      @(negedge clk);
      drive(ind, tgt, msk, 1'b1);
      @(negedge clk);
      chk({tag, ":end_fall0"}, 32'(bus0.fitness_end), 32'h0);
      chk({tag, ":end_fall1"}, 32'(bus1.fitness_end), 32'h0);
      chk({tag, ":end_fall2"}, 32'(bus2.fitness_end), 32'h0);
      drive($urandom, $urandom, $urandom, mode == 1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (mode == 2 && k == 2) drive(~ind, tgt, msk, 1'b1);
         if (mode == 2 && k == 3) set_ti(1'b0);
      end
      chk({tag, ":end_early0"}, 32'(bus0.fitness_end), 32'h0);
      chk({tag, ":end_early2"}, 32'(bus2.fitness_end), 32'h0);
      @(negedge clk);
      chk({tag, ":end_rise0"}, 32'(bus0.fitness_end), 32'h1);
      chk({tag, ":end_rise1"}, 32'(bus1.fitness_end), 32'h1);
      chk({tag, ":end_rise2"}, 32'(bus2.fitness_end), 32'h1);
      chk({tag, ":fit0"}, 32'(bus0.fitness), 32'(e0));
      chk({tag, ":fit1"}, 32'(bus1.fitness), 32'(e1));
      chk({tag, ":fit2"}, 32'(bus2.fitness), 32'(e2));
      repeat (3) @(negedge clk);
      chk({tag, ":hold_end0"}, 32'(bus0.fitness_end), 32'h1);
      chk({tag, ":hold_fit0"}, 32'(bus0.fitness), 32'(e0));
      set_ti(1'b0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b0;
      drive(32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
      repeat (3) @(negedge clk);
      chk("reset_end0", 32'(bus0.fitness_end), 32'h0);
      chk("reset_fit0", 32'(bus0.fitness), 32'h0);
      chk("reset_fit1", 32'(bus1.fitness), 32'h0);
      rst = 1'b1;

      run_eval("equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0);
      run_eval("low_nibble", 32'h0000_000F, 32'h0000_0000, 32'hFFFF_FFFF, 0);
      chk("between_end0", 32'(bus0.fitness_end), 32'h1);
      run_eval("inverse", 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 0);
      run_eval("held_level", 32'h1234_5678, 32'h1234_0000, 32'hFFFF_FFFF, 1);
      run_eval("late_edge", 32'hA5A5_A5A5, 32'h5A5A_A5A5, 32'hFFFF_FFFF, 2);

      // Reset in the middle of an evaluation
      @(negedge clk);
      drive(32'hCAFE_F00D, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b1);
      @(negedge clk);
      set_ti(1'b0);
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_end0", 32'(bus0.fitness_end), 32'h0);
      chk("abort_fit0", 32'(bus0.fitness), 32'h0);
      chk("abort_fit2", 32'(bus2.fitness), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      run_eval("after_reset", 32'h0F0F_0F0F, 32'h0F0F_FFFF, 32'hFFFF_FFFF, 0);

`ifdef FITNESS_MASK_EN
      run_eval("mask_low", 32'h1357_9BDF, 32'h1357_9BDF, 32'h0000_FFFF, 0);
      run_eval("mask_zero", 32'h1357_9BDF, 32'h1357_9BDF, 32'h0000_0000, 0);
`endif

      for (int r = 0; r < 8; r++) begin
         bit [31:0] ri;
         bit [31:0] rt;
         ri = $urandom;
         rt = (r % 2 == 0) ? (ri ^ (32'h1 << $urandom_range(31, 0))) : $urandom;
         run_eval($sformatf("rand%0d", r), ri, rt, $urandom, r % 3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
